// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: post-reset flush, sequential fetch with stall and
// branch redirect, and hand-off of the IRAM port to the program loader.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        LdReq,
    input  logic [31:0] LdAddr,
    output logic        LdGrant,
    output logic [31:0] IAddr,
    output logic        IReq,
    output logic [31:0] PC,
    output logic        Flush
);

    typedef enum logic [1:0] {
        S_FLUSH = 2'b00,
        S_RUN   = 2'b01,
        S_LOAD  = 2'b10
    } state_e;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        ireq_q, ireq_d;
    logic        flush_q, flush_d;
    logic        ldg_q, ldg_d;
    logic [31:0] tgt;

    assign tgt = BranchTarget & ~32'h3;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        iaddr_d = iaddr_q;
        ireq_d  = ireq_q;
        flush_d = flush_q;
        ldg_d   = ldg_q;
        case (state_q)
            S_FLUSH: begin
                ireq_d  = 1'b0;
                flush_d = 1'b1;
                ldg_d   = 1'b0;
                iaddr_d = pc_q;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 4'd0;
                    ireq_d  = 1'b1;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                ireq_d  = 1'b1;
                flush_d = 1'b0;
                ldg_d   = 1'b0;
                // Redirect beats both the loader and a decode stall.
                if (BranchTaken) begin
                    pc_d    = tgt;
                    iaddr_d = tgt;
                    flush_d = 1'b1;
                end else if (LdReq) begin
                    state_d = S_LOAD;
                    ldg_d   = 1'b1;
                    ireq_d  = 1'b0;
                    flush_d = 1'b1;
                    iaddr_d = LdAddr;
                end else if (!Stall) begin
                    pc_d    = pc_q + 32'd4;
                    iaddr_d = pc_q + 32'd4;
                end
            end
            S_LOAD: begin
                flush_d = 1'b1;
                if (LdReq) begin
                    ldg_d   = 1'b1;
                    ireq_d  = 1'b0;
                    iaddr_d = LdAddr;
                end else begin
                    state_d = S_RUN;
                    ldg_d   = 1'b0;
                    ireq_d  = 1'b1;
                    iaddr_d = pc_q;
                end
            end
            default: begin
                state_d = S_FLUSH;
                cnt_d   = 4'd0;
                ireq_d  = 1'b0;
                flush_d = 1'b1;
                ldg_d   = 1'b0;
                iaddr_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_FLUSH;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_VECTOR;
            iaddr_q <= RESET_VECTOR;
            ireq_q  <= 1'b0;
            flush_q <= 1'b1;
            ldg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            iaddr_q <= iaddr_d;
            ireq_q  <= ireq_d;
            flush_q <= flush_d;
            ldg_q   <= ldg_d;
        end
    end

    assign PC      = pc_q;
    assign IAddr   = iaddr_q;
    assign IReq    = ireq_q;
    assign Flush   = flush_q;
    assign LdGrant = ldg_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed per-cycle vectors push their
// expected outputs, a negedge monitor pops and compares.
module tb_fetch_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        LdReq;
    logic [31:0] LdAddr;
    logic        LdGrant;
    logic [31:0] IAddr;
    logic        IReq;
    logic [31:0] PC;
    logic        Flush;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] iaddr;
        logic        ireq;
        logic        flush;
        logic        ldg;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;

    fetch_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .FLUSH_CYCLES(6)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Stall(Stall),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .LdReq(LdReq),
        .LdAddr(LdAddr),
        .LdGrant(LdGrant),
        .IAddr(IAddr),
        .IReq(IReq),
        .PC(PC),
        .Flush(Flush)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: every pushed vector is checked on the following negedge.
    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if (PC !== e.pc || IAddr !== e.iaddr || IReq !== e.ireq ||
                Flush !== e.flush || LdGrant !== e.ldg) begin
                mismatched++;
                $display("FAIL %s: got pc=%h iaddr=%h ireq=%b flush=%b ldg=%b want pc=%h iaddr=%h ireq=%b flush=%b ldg=%b",
                         e.name, PC, IAddr, IReq, Flush, LdGrant,
                         e.pc, e.iaddr, e.ireq, e.flush, e.ldg);
            end
        end
    end

    task automatic step(
        input string       nm,
        input logic        rst,
        input logic        st,
        input logic        br,
        input logic [31:0] tg,
        input logic        ld,
        input logic [31:0] la,
        input logic [31:0] epc,
        input logic [31:0] eia,
        input logic        eir,
        input logic        efl,
        input logic        elg
    );
        exp_t e;
        @(negedge Clk);
        #1;
        Reset        = rst;
        Stall        = st;
        BranchTaken  = br;
        BranchTarget = tg;
        LdReq        = ld;
        LdAddr       = la;
        e.name  = nm;
        e.pc    = epc;
        e.iaddr = eia;
        e.ireq  = eir;
        e.flush = efl;
        e.ldg   = elg;
        sb.push_back(e);
    endtask

    task automatic run(input string nm, input logic [31:0] epc);
        step(nm, 1, 0, 0, 0, 0, 0, epc, epc, 1, 0, 0);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        Reset        = 1'b0;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        LdReq        = 1'b0;
        LdAddr       = 32'h0;

        step("rst0", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("rst1", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("rst_prio", 0, 1, 1, 32'h80, 1, 32'h9, 32'h0, 32'h0, 0, 1, 0);
        // Flush window, with stall/branch/loader noise that must be ignored.
        step("fl0", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("fl1", 1, 1, 1, 32'h50, 1, 32'h9, 32'h0, 32'h0, 0, 1, 0);
        step("fl2", 1, 1, 1, 32'h50, 1, 32'h9, 32'h0, 32'h0, 0, 1, 0);
        step("fl3", 1, 0, 0, 0, 1, 32'h9, 32'h0, 32'h0, 0, 1, 0);
        step("fl4", 1, 0, 0, 0, 1, 32'h9, 32'h0, 32'h0, 0, 1, 0);
        step("first_ireq", 1, 0, 0, 0, 1, 32'h9, 32'h0, 32'h0, 1, 0, 0);
        run("seq4", 32'h4);
        run("seq8", 32'h8);
        run("seqC", 32'hC);
        run("seq10", 32'h10);
        step("stall0", 1, 1, 0, 0, 0, 0, 32'h10, 32'h10, 1, 0, 0);
        step("stall1", 1, 1, 0, 0, 0, 0, 32'h10, 32'h10, 1, 0, 0);
        step("stall2", 1, 1, 0, 0, 0, 0, 32'h10, 32'h10, 1, 0, 0);
        run("post_stall", 32'h14);
        run("seq18", 32'h18);
        run("seq1C", 32'h1C);
        run("seq20", 32'h20);
        step("br_over_stall", 1, 1, 1, 32'h103, 0, 0, 32'h100, 32'h100, 1, 1, 0);
        run("br_flush_once", 32'h104);
        step("br_hi", 1, 0, 1, 32'hFFFF_FFFB, 0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 1, 0);
        run("wrap_pre", 32'hFFFF_FFFC);
        run("wrap", 32'h0);
        step("br40", 1, 0, 1, 32'h40, 0, 0, 32'h40, 32'h40, 1, 1, 0);
        step("ld_enter", 1, 0, 0, 0, 1, 32'h200, 32'h40, 32'h200, 0, 1, 1);
        step("ld_ignore", 1, 1, 1, 32'h80, 1, 32'h204, 32'h40, 32'h204, 0, 1, 1);
        step("ld_exit", 1, 0, 0, 0, 0, 0, 32'h40, 32'h40, 1, 1, 0);
        run("ld_resume", 32'h44);
        step("br_vs_ld", 1, 0, 1, 32'h300, 1, 32'h10, 32'h300, 32'h300, 1, 1, 0);
        step("ld_after_br", 1, 0, 0, 0, 1, 32'h10, 32'h300, 32'h10, 0, 1, 1);
        step("rst_in_load", 0, 0, 0, 0, 1, 32'h14, 32'h0, 32'h0, 0, 1, 0);
        step("refl0", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("refl1", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("refl2", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("refl3", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        step("refl4", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        run("rerun", 32'h0);
        step("rst_mid_br", 0, 0, 1, 32'h500, 0, 0, 32'h0, 32'h0, 0, 1, 0);

        for (int i = 0; i < 5; i++) begin
            if (sb.size() == 0) break;
            @(negedge Clk);
            #2;
        end
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter FLUSH_CYCLES, default 6, legal range 1..15: number of cycles spent in FLUSH after reset.
REQ-003 Clk  input  1  single clock; all state SHALL update on posedge Clk.
REQ-004 Reset  input  1  reset, synchronous and active-low (0 = reset), sampled on posedge Clk.
REQ-005 Stall  input  1  hazard stall from decode; holds PC.
REQ-006 BranchTaken  input  1  redirect request from execute.
REQ-007 BranchTarget  input  32  redirect address; bits [1:0] SHALL be ignored and forced to 0.
REQ-008 LdReq  input  1  program-loader request for the IRAM port.
REQ-009 LdAddr  input  32  loader IRAM word address.
REQ-010 LdGrant  output  1  loader owns the IRAM port.
REQ-011 IAddr  output  32  IRAM address.
REQ-012 IReq  output  1  fetch read enable to IRAM.
REQ-013 PC  output  32  address of the instruction currently being fetched.
REQ-014 Flush  output  1  fetch stage SHALL insert NOP (32'h0) while high.

Function
REQ-015 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-016 The controller SHALL implement states FLUSH, RUN and LOAD, encoded in 2 bits; the unused encoding SHALL return to FLUSH.
REQ-017 FLUSH: Flush=1, IReq=0, LdGrant=0, PC held; a 4-bit counter SHALL increment each cycle, and the state SHALL go to RUN once FLUSH_CYCLES cycles have elapsed.
REQ-018 RUN: IReq=1, IAddr=PC, Flush=0 unless set by REQ-020/REQ-023.
REQ-019 RUN with Stall=1 and BranchTaken=0: PC, IAddr and IReq SHALL hold.
REQ-020 RUN with BranchTaken=1: next PC=BranchTarget&~3; Flush=1 for exactly one cycle. BranchTaken SHALL override Stall.
REQ-021 RUN with Stall=0 and BranchTaken=0: next PC=PC+4, modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-022 RUN with LdReq=1 and BranchTaken=0: the state SHALL go to LOAD; PC frozen; LdGrant=1 from the next cycle. With BranchTaken=1 the branch SHALL win and LdReq is re-evaluated on the following cycle.
REQ-023 LOAD: LdGrant=1, IReq=0, Flush=1, IAddr=LdAddr (registered, one-cycle latency). When LdReq falls, the state SHALL go to RUN, LdGrant SHALL fall in the same cycle, PC resumes from its frozen value and Flush SHALL stay 1 for one extra cycle.
REQ-024 LdReq asserted in FLUSH SHALL be held off until RUN is reached.
REQ-025 Stall and BranchTaken SHALL be ignored in FLUSH and LOAD.

Reset
REQ-026 On posedge Clk with Reset=0: state=FLUSH, counter=0, PC=RESET_VECTOR, IAddr=RESET_VECTOR, IReq=0, LdGrant=0, Flush=1.
REQ-027 Reset asserted in any state, including mid-LOAD or mid-branch, SHALL take priority over every other input in that cycle.
REQ-028 After Reset returns to 1, the first IReq=1 SHALL occur exactly FLUSH_CYCLES cycles later.

Verification
REQ-029 Reset low 3 cycles then high, FLUSH_CYCLES=6 -> Flush=1 for 6 cycles; then IReq=1 with PC=0,4,8,... each cycle.
REQ-030 In RUN at PC=0x10, Stall=1 for 3 cycles -> PC holds at 0x10 for 3 cycles, then 0x14.
REQ-031 At PC=0x20, BranchTaken=1 and Stall=1 with BranchTarget=0x103 -> next PC=0x100, Flush=1 for one cycle only.
REQ-032 PC=0xFFFFFFF8, no stall -> PC sequence 0xFFFFFFFC, then 0x0.
REQ-033 LdReq=1 at PC=0x40, LdAddr=0x200 -> LdGrant=1, IAddr=0x200, IReq=0; when LdReq drops -> LdGrant=0, Flush=1 one extra cycle, fetch resumes at PC=0x40.
REQ-034 Reset driven low during LOAD -> next cycle LdGrant=0, PC=RESET_VECTOR, state FLUSH.
